// File: rtl/sfixed_accum_buffer_if.sv
// rtl/sfixed_accum_buffer_if.sv - stream handshake bundle for the accumulation buffer
//
// Purpose: carries the input beat handshake and the output sum handshake.
// Ports (signals):
//   in_valid/in_ready/data_in    : partial-sum beats into the buffer
//   out_valid/out_ready/data_out : final sums out of the buffer
// Modports: master = source/sink side, slave = buffer side.
interface sfixed_accum_buffer_if #(
  parameter int W      = 32,
  parameter int NUM_CH = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_CH*W-1:0]   data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_CH*W-1:0]   data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/sfixed_accum_buffer.sv
// rtl/sfixed_accum_buffer.sv - multi-lane saturating fixed-point accumulation buffer
//
// Purpose: sums cfg_passes passes of cfg_depth beats per lane into a line buffer
// and streams the final sums out during the last pass.
// Ports:
//   clk, reset (async, active-low)
//   start, cfg_depth, cfg_passes : frame launch and run-time configuration
//   bus (slave)                  : input beats and output sums with valid/ready
//   busy, done, sat_flag, cfg_err: frame status
module sfixed_accum_buffer #(
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int FIFO_DEPTH = 128,
  parameter int NUM_CH     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           cfg_depth,
  input  logic [7:0]            cfg_passes,
  sfixed_accum_buffer_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag,
  output logic                  cfg_err
);
  localparam int W  = INT_WIDTH + FRAC_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [16:0] MAX_D = 17'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       index_q, index_d;
  logic [AW-1:0]       depth_m1_q, depth_m1_d;
  logic [7:0]          pass_q, pass_d;
  logic [7:0]          passes_m1_q, passes_m1_d;
  logic                out_valid_q, out_valid_d;
  logic [NUM_CH*W-1:0] data_out_q, data_out_d;
  logic                sat_q, sat_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                mem_we;

  logic [NUM_CH*W-1:0] mem_q [FIFO_DEPTH];
  logic [NUM_CH*W-1:0] mem_rd;
  logic [NUM_CH*W-1:0] sum_word;
  logic [NUM_CH-1:0]   lane_ovf;
  logic                last_pass, in_ready, accept, out_fire, cfg_bad;

  assign mem_rd = mem_q[index_q];

  // Per-lane add in W+1 bits; a differing top pair of bits means the true
  // result left the W-bit range, and the extra sign bit picks the clamp side.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [W-1:0] acc, inp;
    logic [W:0]   ext;
    assign acc = (pass_q == 8'd0) ? '0 : mem_rd[k*W +: W];
    assign inp = bus.data_in[k*W +: W];
    assign ext = {acc[W-1], acc} + {inp[W-1], inp};
    assign lane_ovf[k] = ext[W] ^ ext[W-1];
    assign sum_word[k*W +: W] = !lane_ovf[k] ? ext[W-1:0] :
                                ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  assign last_pass = (pass_q == passes_m1_q);
  // Final pass feeds a single output register; it may refill in the same
  // cycle the downstream takes the current sum.
  assign in_ready  = (state_q == RUN) && (!last_pass || !out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign cfg_bad   = (cfg_depth == 16'd0) || ({1'b0, cfg_depth} > MAX_D) || (cfg_passes == 8'd0);

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    depth_m1_d  = depth_m1_q;
    pass_d      = pass_q;
    passes_m1_d = passes_m1_q;
    out_valid_d = out_valid_q && !out_fire;
    data_out_d  = data_out_q;
    sat_d       = sat_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            depth_m1_d  = AW'(cfg_depth - 16'd1);
            passes_m1_d = cfg_passes - 8'd1;
            sat_d       = 1'b0;
            index_d     = '0;
            pass_d      = 8'd0;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          sat_d = sat_q || (|lane_ovf);
          if (last_pass) begin
            data_out_d  = sum_word;
            out_valid_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
          if (index_q == depth_m1_q) begin
            index_d = '0;
            if (last_pass) state_d = FLUSH;
            else           pass_d  = pass_q + 8'd1;
          end else begin
            index_d = index_q + AW'(1);
          end
        end
      end
      FLUSH: begin
        // Stay one extra cycle so busy is still high while done pulses.
        if (done_q)        state_d = IDLE;
        else if (out_fire) done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      depth_m1_q  <= '0;
      pass_q      <= 8'd0;
      passes_m1_q <= 8'd0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      depth_m1_q  <= depth_m1_d;
      pass_q      <= pass_d;
      passes_m1_q <= passes_m1_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Line memory is never cleared: pass 0 ignores its contents and overwrites.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[index_q] <= sum_word;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign sat_flag      = sat_q;
  assign cfg_err       = cfg_err_q;
endmodule

// File: doc/sfixed_accum_buffer.md
Name: sfixed_accum_buffer

Overview:
Multi-lane signed fixed-point accumulation buffer for the conv accelerator. Sums partial results over a run-time number of passes (input channels) into a run-time-sized line of entries, then streams the final sums downstream. Replaces the fixed-depth accumulating FIFO with:
- runtime depth and pass count
- NUM_CH parallel lanes
- saturating arithmetic
- valid/ready handshakes on both sides
- start/done framing

Parameters:
INT_WIDTH, 16, integer bits per lane (sign included)
FRAC_WIDTH, 16, fractional bits per lane; lane width W = INT_WIDTH+FRAC_WIDTH
FIFO_DEPTH, 128, maximum entries per pass
NUM_CH, 1, parallel lanes sharing one index/handshake

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  1-cycle pulse; latches cfg_* and begins a frame
cfg_depth  input  16  entries per pass, legal 1..FIFO_DEPTH
cfg_passes  input  8  passes per frame, legal 1..255
in_valid  input  1  data_in beat valid
in_ready  output  1  beat accepted when in_valid&in_ready
data_in  input  NUM_CH*W  lane k at bits [k*W+W-1 : k*W], two's complement
out_valid  output  1  data_out holds a final sum
out_ready  input  1  downstream accepts when out_valid&out_ready
data_out  output  NUM_CH*W  final accumulated sums, same packing
busy  output  1  high from accepted start until done
done  output  1  1-cycle pulse when the last output beat is accepted
sat_flag  output  1  sticky: any lane saturated this frame
cfg_err  output  1  1-cycle pulse on start with illegal config

Behaviour:
- Reset (reset=0, async): state=IDLE. in_ready, out_valid, busy, done, sat_flag, cfg_err=0. data_out=0, index=0, pass=0. Memory is not cleared; the first pass overwrites it.
- States: IDLE, RUN, FLUSH.
- IDLE, start=1:
  - cfg_depth==0, cfg_depth>FIFO_DEPTH, or cfg_passes==0 -> cfg_err=1 next cycle; stay IDLE.
  - Otherwise latch depth D and passes P, clear sat_flag, index=0, pass=0 -> RUN, busy=1.
- start while busy is ignored.
- RUN, per accepted beat, per lane:
  - pass==0: sum = data_in.
  - pass>0: sum = sat(mem[index] + data_in).
  - pass<P-1: mem[index] <= sum.
  - pass==P-1: data_out <= sum, out_valid <= 1; memory not written.
  - P==1 passes data straight through.
- Arithmetic: lane add in W+1 bits.
  - Result > 2^(W-1)-1 clamps to max positive.
  - Result < -2^(W-1) clamps to min negative.
  - Any clamp sets sat_flag.
  - No rounding; binary point is unchanged.
- Index: increments per accepted beat. At index==D-1: index<=0, pass<=pass+1. If pass==P-1, go to FLUSH instead.
- in_ready:
  - 0 in IDLE and FLUSH.
  - RUN with pass<P-1: 1.
  - RUN with pass==P-1: !out_valid | out_ready (single-entry output register with pass-through on acceptance).
- Latency: final-pass beat accepted at cycle N -> out_valid with its sum at N+1. Throughput is 1 beat/cycle with out_ready held 1.
- out_valid/data_out hold stable until accepted. out_valid clears on acceptance unless a new beat loads that same cycle.
- FLUSH: wait for the last out beat to be accepted -> done=1 for 1 cycle, busy=0, -> IDLE. sat_flag holds until the next legal start.
- Simultaneous: done and a new start in the same cycle -> start ignored; busy still 1 that cycle.
- in_valid while in_ready=0: beat not consumed; source must hold it.
- Reset mid-frame: everything returns to reset values immediately; a partially accumulated frame is discarded.

Test Plan:
- Q16.16, NUM_CH=1, D=4, P=3; each pass sends 1.0,2.0,-1.0,0.5 (0x00010000,0x00020000,0xFFFF0000,0x00008000), out_ready=1 -> outputs 0x00030000,0x00060000,0xFFFD0000,0x00018000; done 1 cycle after the 4th output; sat_flag=0.
- P=1, D=3, inputs 5,6,7 (raw) -> outputs 5,6,7 at 1-cycle latency; memory untouched.
- Saturation: D=1, P=2, inputs 0x7FFF0000 then 0x00020000 -> output 0x7FFFFFFF, sat_flag=1. Next frame 0x80000000 + 0xFFFF0000 -> 0x80000000; sat_flag re-cleared at start, then set.
- Backpressure: D=4, P=2, NUM_CH=2, out_ready low for 3 cycles mid last pass -> in_ready=0 while out_valid&!out_ready; data_out stable; no beat lost or duplicated; lanes independent (lane0 +1, lane1 -1 per beat).
- Config errors: start with cfg_depth=0, then cfg_depth=129, then cfg_passes=0 -> cfg_err pulse each time, busy stays 0. start mid-frame -> ignored, frame completes normally.
- Reset mid-frame: assert reset during pass 1 of D=4, P=2 -> outputs cleared asynchronously. Then a fresh frame with D=2, P=2, inputs 3,4,3,4 -> outputs 6,8 (no stale data).
